// File: rtl/alu_cmd_driver.sv
// Initiator for the ALU operand-bus protocol. It accepts one (op, A, B)
// request, sends start+op+A and then B to the ALU, waits for finish under a
// watchdog, captures one or two result words plus flags, and holds the
// response until it is accepted.
module alu_cmd_driver #(
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_lo,
  output logic [W-1:0] rsp_hi,
  output logic [3:0]   rsp_flags,
  output logic         rsp_timeout,
  output logic         busy,
  output logic         alu_start,
  output logic [3:0]   alu_s,
  output logic [W-1:0] alu_inbus,
  input  logic [W-1:0] alu_outbus,
  input  logic         alu_finish,
  input  logic         alu_negative,
  input  logic         alu_zero,
  input  logic         alu_carry,
  input  logic         alu_overflow
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT, CAP_HI, RESP} state_t;

  state_t         state_reg, state_next;
  logic [3:0]     op_reg, op_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [W-1:0]   rsp_lo_reg, rsp_lo_next;
  logic [W-1:0]   rsp_hi_reg, rsp_hi_next;
  logic [3:0]     rsp_flags_reg, rsp_flags_next;
  logic           rsp_timeout_reg, rsp_timeout_next;
  logic           req_ready_reg, req_ready_next;
  logic           rsp_valid_reg, rsp_valid_next;
  logic           busy_reg, busy_next;
  logic           alu_start_reg, alu_start_next;
  logic [3:0]     alu_s_reg, alu_s_next;
  logic [W-1:0]   alu_inbus_reg, alu_inbus_next;

  // MUL and DIV return a second word (high product / remainder)
  logic two_word;
  assign two_word = (op_reg == 4'b0010) || (op_reg == 4'b0011);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state, datapath capture, and registered-output next values
  always_comb begin
    state_next       = state_reg;
    op_next          = op_reg;
    a_next           = a_reg;
    b_next           = b_reg;
    cnt_next         = cnt_reg;
    rsp_lo_next      = rsp_lo_reg;
    rsp_hi_next      = rsp_hi_reg;
    rsp_flags_next   = rsp_flags_reg;
    rsp_timeout_next = rsp_timeout_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready_reg) begin
          op_next    = req_op;
          a_next     = req_a;
          b_next     = req_b;
          state_next = SEND_A;
        end
      end
      SEND_A: state_next = SEND_B;
      SEND_B: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (alu_finish) begin
          rsp_lo_next      = alu_outbus;
          rsp_flags_next   = {alu_negative, alu_zero, alu_carry, alu_overflow};
          rsp_timeout_next = 1'b0;
          if (two_word) begin
            state_next = CAP_HI;
          end else begin
            rsp_hi_next = '0;
            state_next  = RESP;
          end
        end else begin
          if (cnt_reg < CNT_MAX) cnt_next = cnt_reg + 1'b1;
          // This idle cycle is the TIMEOUT-th one: abort
          if (cnt_reg == CNT_LAST) begin
            rsp_lo_next      = '0;
            rsp_hi_next      = '0;
            rsp_flags_next   = '0;
            rsp_timeout_next = 1'b1;
            state_next       = RESP;
          end
        end
      end
      CAP_HI: begin
        rsp_hi_next = alu_outbus;
        state_next  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_timeout_next = 1'b0;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered copies of what the next state presents
    req_ready_next = (state_next == IDLE);
    busy_next      = (state_next != IDLE);
    rsp_valid_next = (state_next == RESP);
    alu_start_next = (state_next == SEND_A);
    alu_s_next     = alu_s_reg;
    alu_inbus_next = '0;
    if (state_next == SEND_A) begin
      alu_s_next     = op_next;
      alu_inbus_next = a_next;
    end else if (state_next == SEND_B) begin
      alu_s_next     = op_next;
      alu_inbus_next = b_next;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg          <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      cnt_reg         <= '0;
      rsp_lo_reg      <= '0;
      rsp_hi_reg      <= '0;
      rsp_flags_reg   <= '0;
      rsp_timeout_reg <= 1'b0;
      req_ready_reg   <= 1'b1;
      rsp_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      alu_start_reg   <= 1'b0;
      alu_s_reg       <= '0;
      alu_inbus_reg   <= '0;
    end else begin
      op_reg          <= op_next;
      a_reg           <= a_next;
      b_reg           <= b_next;
      cnt_reg         <= cnt_next;
      rsp_lo_reg      <= rsp_lo_next;
      rsp_hi_reg      <= rsp_hi_next;
      rsp_flags_reg   <= rsp_flags_next;
      rsp_timeout_reg <= rsp_timeout_next;
      req_ready_reg   <= req_ready_next;
      rsp_valid_reg   <= rsp_valid_next;
      busy_reg        <= busy_next;
      alu_start_reg   <= alu_start_next;
      alu_s_reg       <= alu_s_next;
      alu_inbus_reg   <= alu_inbus_next;
    end
  end

  assign req_ready   = req_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_lo      = rsp_lo_reg;
  assign rsp_hi      = rsp_hi_reg;
  assign rsp_flags   = rsp_flags_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign busy        = busy_reg;
  assign alu_start   = alu_start_reg;
  assign alu_s       = alu_s_reg;
  assign alu_inbus   = alu_inbus_reg;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: behavioural ALU model with a programmable finish
// delay, a table of directed requests, plus hand-written reset sequences.
module tb_alu_cmd_driver;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_lo, rsp_hi;
  logic [3:0]   rsp_flags;
  logic         rsp_timeout, busy, alu_start;
  logic [3:0]   alu_s;
  logic [W-1:0] alu_inbus, alu_outbus;
  logic         alu_finish, alu_negative, alu_zero, alu_carry, alu_overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int fin_dly = 3;  // finish on this WAIT cycle (1-based); 0 = never

  always #5 clk = ~clk;

  alu_cmd_driver #(.W(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo),
    .rsp_hi(rsp_hi), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .busy(busy), .alu_start(alu_start), .alu_s(alu_s), .alu_inbus(alu_inbus),
    .alu_outbus(alu_outbus), .alu_finish(alu_finish),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow)
  );

  // ---------------- behavioural ALU ----------------
  logic [1:0]  m_phase = 2'd0;
  logic [3:0]  m_op = '0;
  logic [15:0] m_a = '0, m_b = '0;
  int          m_wcnt = 0;
  logic [15:0] m_lo, m_hi;
  logic        m_n, m_z, m_c, m_v;
  logic [16:0] m_sum;
  logic [31:0] m_prod;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 2'd0;
    end else if (alu_start) begin
      m_a     <= alu_inbus;
      m_op    <= alu_s;
      m_phase <= 2'd1;
    end else if (m_phase == 2'd1) begin
      m_b     <= alu_inbus;
      m_phase <= 2'd2;
      m_wcnt  <= 1;
    end else if (m_phase == 2'd2) begin
      if (alu_finish) m_phase <= 2'd3;
      else            m_wcnt  <= m_wcnt + 1;
    end else if (m_phase == 2'd3) begin
      m_phase <= 2'd0;
    end
  end

  always_comb begin
    m_sum  = '0;
    m_prod = '0;
    m_lo   = '0;
    m_hi   = 16'hDEAD;  // junk second word for single-word ops
    m_c    = 1'b0;
    m_v    = 1'b0;
    case (m_op)
      4'b0000: begin
        m_sum = {1'b0, m_a} + {1'b0, m_b};
        m_lo  = m_sum[15:0];
        m_c   = m_sum[16];
        m_v   = (m_a[15] == m_b[15]) && (m_lo[15] != m_a[15]);
      end
      4'b0001: begin
        m_lo = m_a - m_b;
        m_c  = (m_a < m_b);
        m_v  = (m_a[15] != m_b[15]) && (m_lo[15] != m_a[15]);
      end
      4'b0010: begin
        m_prod = 32'(m_a) * 32'(m_b);
        m_lo   = m_prod[15:0];
        m_hi   = m_prod[31:16];
      end
      4'b0011: begin
        if (m_b == 16'd0) begin
          m_lo = 16'hFFFF;
          m_hi = m_a;
        end else begin
          m_lo = m_a / m_b;
          m_hi = m_a % m_b;
        end
      end
      default: m_lo = m_a & m_b;
    endcase
    m_n = m_lo[15];
    m_z = (m_lo == 16'd0);
  end

  assign alu_finish   = (m_phase == 2'd2) && (fin_dly != 0) && (m_wcnt == fin_dly);
  assign alu_outbus   = (m_phase == 2'd2) ? m_lo : (m_phase == 2'd3) ? m_hi : 16'd0;
  assign alu_negative = (m_phase == 2'd2) && m_n;
  assign alu_zero     = (m_phase == 2'd2) && m_z;
  assign alu_carry    = (m_phase == 2'd2) && m_c;
  assign alu_overflow = (m_phase == 2'd2) && m_v;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    int          dly;
    int          hold;
    logic [15:0] lo, hi;
    logic [3:0]  flags;
    logic        to;
    int          lat;
  } vec_t;

  // Issue one request, follow the bus sequence, check the response, accept it.
  task automatic run_req(input int idx, input vec_t v);
    int n;
    fin_dly = v.dly;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    @(negedge clk); n = 1;  // SEND_A
    req_valid = 1'b0; req_a = '0; req_b = '0;
    chk("send_a_start", 32'(alu_start), 32'd1);
    chk("send_a_inbus", 32'(alu_inbus), 32'(v.a));
    chk("send_a_s", 32'(alu_s), 32'(v.op));
    chk("send_a_ready", 32'(req_ready), 32'd0);
    chk("send_a_busy", 32'(busy), 32'd1);
    @(negedge clk); n = 2;  // SEND_B
    chk("send_b_start", 32'(alu_start), 32'd0);
    chk("send_b_inbus", 32'(alu_inbus), 32'(v.b));
    @(negedge clk); n = 3;  // first WAIT cycle
    chk("wait_inbus", 32'(alu_inbus), 32'd0);
    chk("wait_s", 32'(alu_s), 32'(v.op));
    while (!rsp_valid && n < 40) begin
      @(negedge clk); n++;
    end
    chk("latency", 32'(n), 32'(v.lat));
    chk("rsp_lo", 32'(rsp_lo), 32'(v.lo));
    chk("rsp_hi", 32'(rsp_hi), 32'(v.hi));
    chk("rsp_flags", 32'(rsp_flags), 32'(v.flags));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(v.to));
    chk("resp_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < v.hold; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_lo", 32'(rsp_lo), 32'(v.lo));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    $display("txn %0d op=%b a=%h b=%h lo=%h hi=%h flags=%b to=%b lat=%0d",
             idx, v.op, v.a, v.b, rsp_lo, rsp_hi, rsp_flags, rsp_timeout, n);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_timeout", 32'(rsp_timeout), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  vec_t vecs[11];
  vec_t v_one;

  initial begin
    //          op       a        b        dly hold lo       hi       flags    to    lat
    vecs[0]  = '{4'b0000, 16'd5,   16'd2147, 3, 0, 16'h0868, 16'h0000, 4'b0000, 1'b0, 6};
    vecs[1]  = '{4'b0001, 16'd5,   16'd2147, 3, 0, 16'hF7A2, 16'h0000, 4'b1010, 1'b0, 6};
    vecs[2]  = '{4'b0010, 16'd300, 16'd300,  3, 0, 16'h5F90, 16'h0001, 4'b0000, 1'b0, 7};
    vecs[3]  = '{4'b0000, 16'h1234, 16'h0001, 3, 10, 16'h1235, 16'h0000, 4'b0000, 1'b0, 6};
    vecs[4]  = '{4'b0000, 16'd5,   16'd2147, 0, 0, 16'h0000, 16'h0000, 4'b0000, 1'b1, 11};
    vecs[5]  = '{4'b0011, 16'd100, 16'd7,    3, 0, 16'h000E, 16'h0002, 4'b0000, 1'b0, 7};
    vecs[6]  = '{4'b0100, 16'h00F0, 16'h0FF0, 1, 0, 16'h00F0, 16'h0000, 4'b0000, 1'b0, 4};
    vecs[7]  = '{4'b0000, 16'h7FFF, 16'h0001, 2, 0, 16'h8000, 16'h0000, 4'b1001, 1'b0, 5};
    vecs[8]  = '{4'b0000, 16'hFFFF, 16'h0001, 8, 0, 16'h0000, 16'h0000, 4'b0110, 1'b0, 11};
    vecs[9]  = '{4'b0010, 16'hFFFF, 16'hFFFF, 8, 0, 16'h0001, 16'hFFFE, 4'b0000, 1'b0, 12};
    vecs[10] = '{4'b0101, 16'd3,   16'd5,    3, 0, 16'h0001, 16'h0000, 4'b0000, 1'b0, 6};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_alu_inbus", 32'(alu_inbus), 32'd0);
    chk("rst_rsp_lo", 32'(rsp_lo), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_req(i, vecs[i]);

    // Reset while waiting for finish: abort with no response
    fin_dly = 3;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0000; req_a = 16'd5; req_b = 16'd2147;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_inbus", 32'(alu_inbus), 32'd0);
    v_one = '{4'b0000, 16'd1, 16'd1, 3, 0, 16'h0002, 16'h0000, 4'b0000, 1'b0, 6};
    run_req(11, v_one);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
